// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Request/response bundle for the two-port data-memory arbiter:
//            port A, port B and the shared memory-side port.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
    logic        a_req;
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [3:0]  a_wstrb;
    logic        a_gnt;
    logic        a_rvalid;
    logic [31:0] a_rdata;

    logic        b_req;
    logic        b_we;
    logic [31:0] b_addr;
    logic [31:0] b_wdata;
    logic [3:0]  b_wstrb;
    logic        b_gnt;
    logic        b_rvalid;
    logic [31:0] b_rdata;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    // The arbiter masters the memory port and serves both requesters.
    modport master (
        input  a_req, a_we, a_addr, a_wdata, a_wstrb,
        output a_gnt, a_rvalid, a_rdata,
        input  b_req, b_we, b_addr, b_wdata, b_wstrb,
        output b_gnt, b_rvalid, b_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb,
        input  m_ready, m_rvalid, m_rdata
    );

    modport slave (
        output a_req, a_we, a_addr, a_wdata, a_wstrb,
        input  a_gnt, a_rvalid, a_rdata,
        output b_req, b_we, b_addr, b_wdata, b_wstrb,
        input  b_gnt, b_rvalid, b_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb,
        output m_ready, m_rvalid, m_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port data-memory arbiter, A fixed priority with a starvation
//            override for B. Optional DMEM_ARB_STATS_EN adds grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
`ifdef DMEM_ARB_STATS_EN
    output logic [31:0]    a_grant_cnt,
    output logic [31:0]    b_grant_cnt,
`endif
    dmem_arbiter_if.master bus
);
    localparam logic [3:0] c_max_wait = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_owner_b;
    logic       w_owner_b_nxt;
    logic [3:0] r_starve;
    logic       w_sel_b;
    logic       w_req_any;
    logic       w_m_req;
    logic       w_accept;
    logic       w_done;
    logic [3:0] w_wstrb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_owner_b <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner_b <= w_owner_b_nxt;
        end
    end

    assign w_req_any = bus.a_req | bus.b_req;

    // Outside IDLE the latched owner drives the bus, whatever the requesters do.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_b_nxt = r_owner_b;
        w_sel_b       = r_owner_b;
        w_m_req       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel_b = bus.b_req & (~bus.a_req | (r_starve == c_max_wait));
                w_m_req = w_req_any;
                if (w_req_any) begin
                    w_owner_b_nxt = w_sel_b;
                    w_state_nxt   = bus.m_ready ? S_WAIT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_m_req = 1'b1;
                if (bus.m_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.m_rvalid) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = w_m_req & bus.m_ready & ~reset;
    assign w_done   = (r_state == S_WAIT) & bus.m_rvalid & ~reset;

    assign bus.m_req   = w_m_req & ~reset;
    assign bus.m_we    = w_sel_b ? bus.b_we    : bus.a_we;
    assign bus.m_addr  = w_sel_b ? bus.b_addr  : bus.a_addr;
    assign bus.m_wdata = w_sel_b ? bus.b_wdata : bus.a_wdata;
    assign w_wstrb     = w_sel_b ? bus.b_wstrb : bus.a_wstrb;
    assign bus.m_wstrb = bus.m_we ? w_wstrb : 4'b0000;

    assign bus.a_gnt    = w_accept & ~w_sel_b;
    assign bus.b_gnt    = w_accept &  w_sel_b;
    assign bus.a_rvalid = w_done & ~r_owner_b;
    assign bus.b_rvalid = w_done &  r_owner_b;
    assign bus.a_rdata  = bus.m_rdata;
    assign bus.b_rdata  = bus.m_rdata;

    // Counts cycles B has been kept waiting; saturates so the override sticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= 4'd0;
        end else if (!bus.b_req || bus.b_gnt) begin
            r_starve <= 4'd0;
        end else if (r_starve != c_max_wait) begin
            r_starve <= r_starve + 4'd1;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic [31:0] r_a_grant_cnt;
    logic [31:0] r_b_grant_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a_grant_cnt <= 32'd0;
            r_b_grant_cnt <= 32'd0;
        end else begin
            if (bus.a_gnt) r_a_grant_cnt <= r_a_grant_cnt + 32'd1;
            if (bus.b_gnt) r_b_grant_cnt <= r_b_grant_cnt + 32'd1;
        end
    end

    assign a_grant_cnt = r_a_grant_cnt;
    assign b_grant_cnt = r_b_grant_cnt;
`else
    // Statistics disabled: no counter state in this build.
`endif

endmodule
`default_nettype wire
